pci_dataphase_tracker: RTL and testbench

Parametrised data-phase counter for the PCI master/target datapath. It is the next generation of the burst-length counter.
- Loads a burst length at the address phase.
- Counts completed data phases (IRDY# and TRDY# both low).
- Flags the final phase so FRAME# can be deasserted on time.
- Ends the burst on normal completion, target disconnect/retry (STOP#) or a wait-state watchdog timeout.
- Reports how many phases actually transferred.

---
 rtl/pci_dataphase_tracker.sv | 136 +++++++++++++
 tb/tb_pci_dataphase_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_dataphase_tracker.sv
// PCI data-phase tracker: counts completed IRDY#/TRDY# phases for one burst and
// ends the burst on last phase, STOP# or wait-state watchdog.
module pci_dataphase_tracker #(
    parameter int CNT_W    = 8,
    parameter int WAIT_MAX = 16,
    parameter int WAIT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             IRDY,
    input  logic             TRDY,
    input  logic             STOP,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] xfer_count,
    output logic             last_phase,
    output logic             done,
    output logic             disc,
    output logic             timeout,
    output logic             len_err
);

    typedef enum logic {
        IDLE,
        DATA
    } state_e;

    localparam bit WD_EN = (WAIT_MAX != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  xfer_q, xfer_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              done_q, done_d;
    logic              disc_q, disc_d;
    logic              to_q, to_d;
    logic              lerr_q, lerr_d;
    logic              phase_ok;

    assign phase_ok = ~IRDY & ~TRDY;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        xfer_d  = xfer_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        disc_d  = disc_q;
        to_d    = to_q;
        lerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = DATA;
                        rem_d   = len;
                        xfer_d  = '0;
                        disc_d  = 1'b0;
                        to_d    = 1'b0;
                        wait_d  = '0;
                    end else begin
                        lerr_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (phase_ok) begin
                    rem_d  = rem_q - ONE;
                    xfer_d = xfer_q + ONE;
                    wait_d = '0;
                end else if (IRDY) begin
                    wait_d = '0;
                end
                // Priority: normal end beats STOP# on the final phase
                if (phase_ok && rem_q == ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    disc_d  = 1'b0;
                end else if (~STOP && phase_ok) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    disc_d  = 1'b1;
                end else if (~STOP && TRDY) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    disc_d  = 1'b1;
                end else if (WD_EN && ~IRDY && TRDY) begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        to_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            xfer_q  <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            disc_q  <= 1'b0;
            to_q    <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            xfer_q  <= xfer_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            disc_q  <= disc_d;
            to_q    <= to_d;
            lerr_q  <= lerr_d;
        end
    end

    assign busy       = (state_q == DATA);
    assign last_phase = (state_q == DATA) && (rem_q == ONE);
    assign remaining  = rem_q;
    assign xfer_count = xfer_q;
    assign done       = done_q;
    assign disc       = disc_q;
    assign timeout    = to_q;
    assign len_err    = lerr_q;

endmodule

// File: tb/tb_pci_dataphase_tracker.sv
// Directed bench for pci_dataphase_tracker: one watchdog instance (WAIT_MAX=4)
// and one with the watchdog disabled, driven by the same bus.
module tb_pci_dataphase_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       IRDY, TRDY, STOP;

    logic       busy, last_phase, done, disc, timeout, len_err;
    logic [7:0] remaining, xfer_count;
    logic       nw_busy, nw_last, nw_done, nw_disc, nw_to, nw_lerr;
    logic [7:0] nw_rem, nw_xfer;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pci_dataphase_tracker #(.CNT_W(8), .WAIT_MAX(4), .WAIT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .IRDY(IRDY), .TRDY(TRDY), .STOP(STOP),
        .busy(busy), .remaining(remaining), .xfer_count(xfer_count),
        .last_phase(last_phase), .done(done), .disc(disc),
        .timeout(timeout), .len_err(len_err)
    );

    pci_dataphase_tracker #(.CNT_W(8), .WAIT_MAX(0), .WAIT_W(5)) u_nowd (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .IRDY(IRDY), .TRDY(TRDY), .STOP(STOP),
        .busy(nw_busy), .remaining(nw_rem), .xfer_count(nw_xfer),
        .last_phase(nw_last), .done(nw_done), .disc(nw_disc),
        .timeout(nw_to), .len_err(nw_lerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        start = 1'b0;
        IRDY  = 1'b1;
        TRDY  = 1'b1;
        STOP  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        len   = 8'd0;
        bus_idle();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {disc, timeout, len_err, last_phase}, 0);
        rst_n = 1'b1;
        tick();

        // Normal burst of 4, start asserted on the terminating edge
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        chk("nb_busy", busy, 1);
        chk("nb_rem0", remaining, 4);
        chk("nb_xfer0", xfer_count, 0);
        IRDY = 1'b0; TRDY = 1'b0;
        tick();
        chk("nb_rem1", remaining, 3);
        chk("nb_last_early", last_phase, 0);
        tick();
        tick();
        chk("nb_rem3", remaining, 1);
        chk("nb_last", last_phase, 1);
        start = 1'b1; len = 8'd5;
        tick();
        bus_idle();
        chk("nb_done", done, 1);
        chk("nb_busy_fall", busy, 0);
        chk("nb_xfer", xfer_count, 4);
        chk("nb_rem", remaining, 0);
        chk("nb_disc", disc, 0);
        tick();
        chk("nb_done_pulse", done, 0);
        chk("nb_start_ign", busy, 0);
        chk("nb_hold_xfer", xfer_count, 4);

        // Wait states: TRDY 0,1,1,0,0
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        IRDY = 1'b0;
        TRDY = 1'b0; tick();
        chk("ws_rem_a", remaining, 2);
        TRDY = 1'b1; tick();
        TRDY = 1'b1; tick();
        chk("ws_rem_b", remaining, 2);
        chk("ws_busy", busy, 1);
        TRDY = 1'b0; tick();
        chk("ws_rem_c", remaining, 1);
        TRDY = 1'b0; tick();
        bus_idle();
        chk("ws_done", done, 1);
        chk("ws_xfer", xfer_count, 3);
        chk("ws_to", timeout, 0);
        tick();

        // Disconnect with data after 2 phases
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        IRDY = 1'b0; TRDY = 1'b0;
        tick();
        tick();
        chk("dc_xfer2", xfer_count, 2);
        STOP = 1'b0;
        tick();
        bus_idle();
        chk("dc_done", done, 1);
        chk("dc_disc", disc, 1);
        chk("dc_xfer", xfer_count, 3);
        chk("dc_rem", remaining, 5);
        tick();
        chk("dc_disc_hold", disc, 1);

        // Retry on first cycle
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        chk("rt_disc_clr", disc, 0);
        IRDY = 1'b0; TRDY = 1'b1; STOP = 1'b0;
        tick();
        bus_idle();
        chk("rt_done", done, 1);
        chk("rt_disc", disc, 1);
        chk("rt_xfer", xfer_count, 0);
        chk("rt_rem", remaining, 8);
        tick();

        // Watchdog: 4 wait cycles on the WAIT_MAX=4 instance
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        IRDY = 1'b0; TRDY = 1'b1;
        repeat (3) tick();
        chk("wd_busy3", busy, 1);
        chk("wd_done3", done, 0);
        tick();
        chk("wd_done", done, 1);
        chk("wd_to", timeout, 1);
        chk("wd_xfer", xfer_count, 0);
        chk("wd_disc", disc, 0);
        chk("nw_busy_a", nw_busy, 1);
        repeat (6) tick();
        chk("nw_busy_b", nw_busy, 1);
        chk("nw_done_b", nw_done, 0);
        TRDY = 1'b0;
        tick();
        tick();
        bus_idle();
        chk("nw_done", nw_done, 1);
        chk("nw_xfer", nw_xfer, 2);
        chk("wd_to_hold", timeout, 1);
        tick();

        // Master wait (IRDY high) clears the wait counter
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        IRDY = 1'b0; TRDY = 1'b1;
        repeat (3) tick();
        IRDY = 1'b1;
        tick();
        IRDY = 1'b0;
        repeat (3) tick();
        chk("mw_busy", busy, 1);
        chk("mw_to", timeout, 0);
        TRDY = 1'b0;
        tick();
        tick();
        bus_idle();
        chk("mw_done", done, 1);
        chk("mw_xfer", xfer_count, 2);
        tick();

        // len == 0
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        chk("lz_err", len_err, 1);
        chk("lz_busy", busy, 0);
        chk("lz_xfer_keep", xfer_count, 2);
        tick();
        chk("lz_err_pulse", len_err, 0);

        // Full 255-phase burst with a start mid-burst
        start = 1'b1; len = 8'd255;
        tick();
        IRDY = 1'b0; TRDY = 1'b0;
        len = 8'd7;
        tick();
        start = 1'b0;
        chk("fb_start_ign", remaining, 254);
        repeat (253) tick();
        chk("fb_last", last_phase, 1);
        chk("fb_xfer254", xfer_count, 254);
        tick();
        bus_idle();
        chk("fb_done", done, 1);
        chk("fb_xfer", xfer_count, 255);
        chk("fb_rem", remaining, 0);
        tick();

        // Asynchronous reset mid-burst
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        IRDY = 1'b0; TRDY = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_xfer", xfer_count, 0);
        chk("ar_rem", remaining, 0);
        tick();
        chk("ar_done", done, 0);
        bus_idle();
        rst_n = 1'b1;
        tick();
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        chk("ar_last", last_phase, 1);
        IRDY = 1'b0; TRDY = 1'b0;
        tick();
        bus_idle();
        chk("ar_done2", done, 1);
        chk("ar_xfer2", xfer_count, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
